// File: rtl/kirsch_pkg.sv
// Shared definitions for the Kirsch edge-detection pipeline.
// Pixel width default, window FSM states and 3x3 window index map.
package kirsch_pkg;

    localparam int DW_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Row-major 3x3 window positions, shared with the kernel blocks.
    localparam int P1   = 0;
    localparam int P2   = 1;
    localparam int P3   = 2;
    localparam int P4   = 3;
    localparam int P5   = 4;
    localparam int P6   = 5;
    localparam int P7   = 6;
    localparam int P8   = 7;
    localparam int P9   = 8;
    localparam int NWIN = 9;

endpackage

// File: rtl/kirsch_line_buffer.sv
// One image line of storage: a single array, one read and one write at
// the same address per cycle. Ports: clk, we_i, addr_i, wdata_i, rdata_o.
module kirsch_line_buffer #(
    parameter int DEPTH = 640,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];

    // Contents are never reset; consumers gate stale data with validity.
    always_ff @(posedge clk) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

    // Asynchronous read returns the value from before this edge's write.
    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/kirsch_window_gen.sv
// Raster pixel stream to registered 3x3 windows (p1..p9) for the Kirsch
// kernels. Ports: clk, rst_n, in_valid/in_sof/in_pixel in; window, pulses out.
module kirsch_window_gen
    import kirsch_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_pixel,
    output logic [DW-1:0] p1,
    output logic [DW-1:0] p2,
    output logic [DW-1:0] p3,
    output logic [DW-1:0] p4,
    output logic [DW-1:0] p5,
    output logic [DW-1:0] p6,
    output logic [DW-1:0] p7,
    output logic [DW-1:0] p8,
    output logic [DW-1:0] p9,
    output logic          win_valid,
    output logic          frame_done,
    output logic          frame_abort
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          accept, restart, last, win_ok;
    logic [DW-1:0] lb0_rd, lb1_rd;
    logic [DW-1:0] new_col [3];
    // a_q holds the older column, b_q the newer; rows top/mid/bottom.
    logic [DW-1:0] a_q [3];
    logic [DW-1:0] b_q [3];
    logic [DW-1:0] win_q [NWIN];
    logic          win_valid_q, frame_done_q, frame_abort_q;

    kirsch_line_buffer #(.DEPTH(IMG_W), .W(DW), .AW(CW)) u_lb0 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (cur_col),
        .wdata_i (in_pixel),
        .rdata_o (lb0_rd)
    );

    // lb1 inherits the line lb0 held before this write.
    kirsch_line_buffer #(.DEPTH(IMG_W), .W(DW), .AW(CW)) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (cur_col),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    always_comb begin
        restart = in_valid & in_sof;
        accept  = in_valid & (in_sof | (state_q == STREAM));
        // A start-of-frame pixel is (0,0) regardless of the counters.
        cur_col = restart ? '0 : col_q;
        cur_row = restart ? '0 : row_q;
        last    = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
        win_ok  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        new_col[0] = lb1_rd;
        new_col[1] = lb0_rd;
        new_col[2] = in_pixel;

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            if (last) begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
            end else begin
                state_d = STREAM;
                if (cur_col == CW'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = cur_row + 1'b1;
                end else begin
                    col_d = cur_col + 1'b1;
                    row_d = cur_row;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            a_q           <= '{default: '0};
            b_q           <= '{default: '0};
            win_q         <= '{default: '0};
            win_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            win_valid_q   <= win_ok;
            frame_done_q  <= accept & last;
            frame_abort_q <= restart & (state_q == STREAM);
            if (accept) begin
                a_q <= b_q;
                b_q <= new_col;
            end
            if (win_ok) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[3*i]     <= a_q[i];
                    win_q[3*i + 1] <= b_q[i];
                    win_q[3*i + 2] <= new_col[i];
                end
            end
        end
    end

    assign p1          = win_q[P1];
    assign p2          = win_q[P2];
    assign p3          = win_q[P3];
    assign p4          = win_q[P4];
    assign p5          = win_q[P5];
    assign p6          = win_q[P6];
    assign p7          = win_q[P7];
    assign p8          = win_q[P8];
    assign p9          = win_q[P9];
    assign win_valid   = win_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

endmodule
